// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 33-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic                 sa_q, sa_d, sb_q, sb_d, busy_q, busy_d, done_q, done_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]       mul_sum, shifted, diff;
  logic [2*WIDTH-1:0]   mul_acc, div_acc, prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;
  logic                 neg_q, neg_r;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{b_q[0]}} & a_q};
  assign mul_acc  = {mul_sum, acc_q[WIDTH-1:1]};
  assign shifted  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, b_q};
  assign div_acc  = {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~diff[WIDTH]};
  assign prod_fix = (op_q[0] & (sa_q ^ sb_q)) ? -acc_q : acc_q;
  assign neg_q    = op_q[0] & (sa_q ^ sb_q) & (b_q != '0);
  assign neg_r    = op_q[0] & sa_q & (b_q != '0);
  assign q_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_fix    = neg_r ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          sa_d    = op[0] & rs_data[WIDTH-1];
          sb_d    = op[0] & rt_data[WIDTH-1];
          a_d     = (op[0] & rs_data[WIDTH-1]) ? -rs_data : rs_data;
          b_d     = (op[0] & rt_data[WIDTH-1]) ? -rt_data : rt_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          hi_d = hi_we ? wdata : hi_q;
          lo_d = lo_we ? wdata : lo_q;
        end
      end
      CALC: begin
        acc_d   = op_q[1] ? div_acc : mul_acc;
        a_d     = op_q[1] ? a_q << 1 : a_q;
        b_d     = op_q[1] ? b_q : b_q >> 1;
        cnt_d   = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(WIDTH - 1)) ? FIX : CALC;
      end
      FIX: begin
        hi_d    = op_q[1] ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_d    = op_q[1] ? q_fix : prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
